// File: rtl/prescaler_prog.sv
// -----------------------------------------------------------------------------
// prescaler_prog
//   Runtime-programmable clock prescaler. It divides clk_in by a loadable
//   divisor D and produces:
//     - tick    : a one-cycle strobe every D enabled cycles;
//     - clk_out : a 50%-duty divided clock of period 2*D.
//   New divisors are captured into a shadow register. The shadow value is
//   applied at the next terminal count, so clk_out never glitches.
//
// Optional build macro: PRESCALER_ONESHOT_EN
//   When defined, the oneshot/done ports are added. With oneshot=1, the
//   block stops after its first wrap. It re-arms on the first edge with en=0.
//
// Parameters:
//   N           counter and divisor width in bits
//   DIV_DEFAULT divisor loaded at reset (2**(N-1))
//
// Ports:
//   clk_in    in   system clock; all logic runs on its rising edge
//   rst       in   asynchronous, active-high reset
//   en        in   count enable; 0 freezes the counter
//   div_in    in   [N] new divisor value
//   div_load  in   one-cycle strobe; captures div_in into the shadow register
//   oneshot   in   (macro only) stop after the first wrap
//   done      out  (macro only) set by a oneshot wrap, cleared by en=0
//   tick      out  one-cycle pulse on each terminal count
//   clk_out   out  divided clock; toggles on each tick
//   div_pend  out  a shadow divisor is waiting for the next wrap
//   count_out out  [N] current counter value
// -----------------------------------------------------------------------------
module prescaler_prog #(
   parameter int unsigned     N           = 22,
   parameter logic [N-1:0]    DIV_DEFAULT = {1'b1, {(N-1){1'b0}}}
) (
   input  logic         clk_in,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] div_in,
   input  logic         div_load,
`ifdef PRESCALER_ONESHOT_EN
   input  logic         oneshot,
   output logic         done,
`endif
   output logic         tick,
   output logic         clk_out,
   output logic         div_pend,
   output logic [N-1:0] count_out
);

   localparam logic [N-1:0] ONE = N'(1);

   logic [N-1:0] count;
   logic [N-1:0] div_q;   // active divisor
   logic [N-1:0] shd;     // shadow divisor, applied at the next wrap
   logic         frozen;  // oneshot has fired and is waiting for en=0
   logic         run;
   logic         wrap;
   logic         load_now;

`ifdef PRESCALER_ONESHOT_EN
   assign frozen = done;
`else
   assign frozen = 1'b0;
`endif

   assign count_out = count;

   always_comb begin
      run      = en && (div_q != '0) && !frozen;
      wrap     = run && (count == div_q - ONE);
      // When nothing is counting, a new divisor cannot cause a glitch.
      // It is therefore applied in the same edge instead of waiting for a
      // wrap that may never come.
      load_now = div_load && (!en || (div_q == '0));
   end

   // NOTE: async reset in the sensitivity list, and non-blocking assignments
   // throughout. Later assignments in the block override earlier ones. The
   // load handling therefore deliberately follows the wrap handling, so a
   // load on a wrap edge leaves the new value pending.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         count    <= '0;
         div_q    <= DIV_DEFAULT;
         shd      <= '0;
         tick     <= 1'b0;
         clk_out  <= 1'b0;
         div_pend <= 1'b0;
`ifdef PRESCALER_ONESHOT_EN
         done     <= 1'b0;
`endif
      end else begin
         tick <= 1'b0;

         if (wrap) begin
            count   <= '0;
            tick    <= 1'b1;
            clk_out <= ~clk_out;
            if (div_pend) begin
               div_q    <= shd;
               div_pend <= 1'b0;
            end
         end else if (run) begin
            count <= count + ONE;
         end

         if (div_load) begin
            shd <= div_in;
            if (load_now) begin
               div_q    <= div_in;
               count    <= '0;
               div_pend <= 1'b0;
            end else begin
               div_pend <= 1'b1;
            end
         end

`ifdef PRESCALER_ONESHOT_EN
         if (!en)
            done <= 1'b0;
         else if (wrap && oneshot)
            done <= 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_prescaler_prog.sv
// -----------------------------------------------------------------------------
// tb_prescaler_prog
//   Self-checking bench for prescaler_prog (N=8, DIV_DEFAULT=128).
//
//   Stimulus comes from a table of per-cycle records. Each record holds the
//   inputs for one edge and the outputs expected after that edge. The
//   expected half is pushed to a scoreboard when the inputs are driven. It is
//   popped and compared 1 ns after the rising edge.
//
//   Hand-written sequences cover the remaining cases:
//     - asynchronous reset mid-count;
//     - the reset-default divisor;
//     - the oneshot mode (only when PRESCALER_ONESHOT_EN is defined).
// -----------------------------------------------------------------------------
module tb_prescaler_prog;

   localparam int N = 8;

   typedef struct {
      logic         en;
      logic         ld;
      logic [N-1:0] din;
      logic         os;
      logic [N-1:0] cnt;
      logic         tick;
      logic         clk_out;
      logic         pend;
      logic         done;
   } vec_t;

   logic         clk_in = 1'b0;
   logic         rst;
   logic         en;
   logic [N-1:0] div_in;
   logic         div_load;
   logic         tick;
   logic         clk_out;
   logic         div_pend;
   logic [N-1:0] count_out;
`ifdef PRESCALER_ONESHOT_EN
   logic         oneshot;
   logic         done;
`endif

   vec_t vecs[$];
   vec_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   step_no  = 0;

   always #5 clk_in = ~clk_in;

   prescaler_prog #(.N(N)) dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .en       (en),
      .div_in   (div_in),
      .div_load (div_load),
`ifdef PRESCALER_ONESHOT_EN
      .oneshot  (oneshot),
      .done     (done),
`endif
      .tick     (tick),
      .clk_out  (clk_out),
      .div_pend (div_pend),
      .count_out(count_out)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic vec_t mk(input logic e, input logic l, input logic [N-1:0] d,
                               input logic o, input logic [N-1:0] c, input logic t,
                               input logic k, input logic p, input logic dn);
      vec_t v;
      v.en = e;  v.ld = l;  v.din = d;  v.os = o;
      v.cnt = c; v.tick = t; v.clk_out = k; v.pend = p; v.done = dn;
      return v;
   endfunction

   // Drive one record at the falling edge, then score after the rising edge.
   task automatic step(input vec_t v);
      vec_t exp;
      @(negedge clk_in);
      en       = v.en;
      div_load = v.ld;
      div_in   = v.din;
`ifdef PRESCALER_ONESHOT_EN
      oneshot  = v.os;
`endif
      sb.push_back(v);
      @(posedge clk_in);
      #1;
      exp = sb.pop_front();
      step_no++;
      check($sformatf("s%0d_count", step_no), 32'(count_out), 32'(exp.cnt));
      check($sformatf("s%0d_tick", step_no), 32'(tick), 32'(exp.tick));
      check($sformatf("s%0d_clk_out", step_no), 32'(clk_out), 32'(exp.clk_out));
      check($sformatf("s%0d_div_pend", step_no), 32'(div_pend), 32'(exp.pend));
`ifdef PRESCALER_ONESHOT_EN
      check($sformatf("s%0d_done", step_no), 32'(done), 32'(exp.done));
`endif
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; div_load = 1'b0; div_in = '0;
`ifdef PRESCALER_ONESHOT_EN
      oneshot = 1'b0;
`endif

      // ---------------- vector table: en ld din os | cnt tick clk pend done
      // Immediately load divisor 4 while disabled.
      vecs.push_back(mk(0,1,4,0, 0,0,0,0,0));
      // Divisor 4: tick every 4 edges; clk_out period 8. One en=0 hold cycle.
      vecs.push_back(mk(1,0,0,0, 1,0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 2,0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 3,0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 0,1,1,0,0));
      vecs.push_back(mk(1,0,0,0, 1,0,1,0,0));
      vecs.push_back(mk(0,0,0,0, 1,0,1,0,0));
      vecs.push_back(mk(1,0,0,0, 2,0,1,0,0));
      vecs.push_back(mk(1,0,0,0, 3,0,1,0,0));
      vecs.push_back(mk(1,0,0,0, 0,1,0,0,0));
      vecs.push_back(mk(1,0,0,0, 1,0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 2,0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 3,0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 0,1,1,0,0));
      // Divisor 5, then shadow-load 3 at count 2; applied at the wrap.
      vecs.push_back(mk(0,1,5,0, 0,0,1,0,0));
      vecs.push_back(mk(1,0,0,0, 1,0,1,0,0));
      vecs.push_back(mk(1,0,0,0, 2,0,1,0,0));
      vecs.push_back(mk(1,1,3,0, 3,0,1,1,0));
      vecs.push_back(mk(1,0,0,0, 4,0,1,1,0));
      vecs.push_back(mk(1,0,0,0, 0,1,0,0,0));
      vecs.push_back(mk(1,0,0,0, 1,0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 2,0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 0,1,1,0,0));
      vecs.push_back(mk(1,0,0,0, 1,0,1,0,0));
      vecs.push_back(mk(1,0,0,0, 2,0,1,0,0));
      vecs.push_back(mk(1,0,0,0, 0,1,0,0,0));
      // en=0 load 7: immediate; then the first tick arrives 7 edges later.
      vecs.push_back(mk(0,1,7,0, 0,0,0,0,0));
      for (int i = 1; i <= 6; i++)
         vecs.push_back(mk(1,0,0,0, N'(i),0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 0,1,1,0,0));
      // Load 0, then 1, before the wrap: only 1 is applied.
      vecs.push_back(mk(1,1,0,0, 1,0,1,1,0));
      vecs.push_back(mk(1,1,1,0, 2,0,1,1,0));
      for (int i = 3; i <= 6; i++)
         vecs.push_back(mk(1,0,0,0, N'(i),0,1,1,0));
      vecs.push_back(mk(1,0,0,0, 0,1,0,0,0));
      // Divisor 1: tick every cycle, clk_out at half rate.
      vecs.push_back(mk(1,0,0,0, 0,1,1,0,0));
      vecs.push_back(mk(1,0,0,0, 0,1,0,0,0));
      vecs.push_back(mk(1,0,0,0, 0,1,1,0,0));
      // Load 0 on a wrap edge: it becomes pending and is applied at the next wrap.
      vecs.push_back(mk(1,1,0,0, 0,1,0,1,0));
      vecs.push_back(mk(1,0,0,0, 0,1,1,0,0));
      // Halted: no ticks, clk_out holds.
      vecs.push_back(mk(1,0,0,0, 0,0,1,0,0));
      vecs.push_back(mk(1,0,0,0, 0,0,1,0,0));
      vecs.push_back(mk(1,0,0,0, 0,0,1,0,0));
      // A load while halted applies immediately, even with en=1.
      vecs.push_back(mk(1,1,4,0, 0,0,1,0,0));
      vecs.push_back(mk(1,0,0,0, 1,0,1,0,0));
      vecs.push_back(mk(1,1,9,0, 2,0,1,1,0));
      vecs.push_back(mk(1,0,0,0, 3,0,1,1,0));

      // ---------------- reset values
      #12;
      check("rst_count", 32'(count_out), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_clk_out", 32'(clk_out), 32'd0);
      check("rst_div_pend", 32'(div_pend), 32'd0);
      @(negedge clk_in);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i]);

      // ---------------- async reset mid-count (count=3, clk_out=1, div_pend=1)
      #2;
      rst = 1'b1;
      #1;
      check("arst_count", 32'(count_out), 32'd0);
      check("arst_clk_out", 32'(clk_out), 32'd0);
      check("arst_div_pend", 32'(div_pend), 32'd0);
      check("arst_tick", 32'(tick), 32'd0);
      en = 1'b0;
      div_load = 1'b0;
      @(posedge clk_in);
      #1;
      check("arst_hold_count", 32'(count_out), 32'd0);
      @(negedge clk_in);
      rst = 1'b0;

      // ---------------- reset divisor is DIV_DEFAULT = 128
      for (int i = 1; i <= 127; i++)
         step(mk(1,0,0,0, N'(i),0,0,0,0));
      step(mk(1,0,0,0, 0,1,1,0,0));

`ifdef PRESCALER_ONESHOT_EN
      // ---------------- oneshot with divisor 3
      step(mk(0,1,3,1, 0,0,1,0,0));
      step(mk(1,0,0,1, 1,0,1,0,0));
      step(mk(1,0,0,1, 2,0,1,0,0));
      step(mk(1,0,0,1, 0,1,0,0,1));
      for (int i = 0; i < 10; i++)
         step(mk(1,0,0,1, 0,0,0,0,1));
      step(mk(0,0,0,1, 0,0,0,0,0));
      step(mk(1,0,0,1, 1,0,0,0,0));
      step(mk(1,0,0,1, 2,0,0,0,0));
      step(mk(1,0,0,1, 0,1,1,0,1));
      // Back to free-running after re-arming.
      step(mk(0,0,0,0, 0,0,1,0,0));
      step(mk(1,0,0,0, 1,0,1,0,0));
      step(mk(1,0,0,0, 2,0,1,0,0));
      step(mk(1,0,0,0, 0,1,0,0,0));
      step(mk(1,0,0,0, 1,0,0,0,0));
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/prescaler_prog.md
Name: prescaler_prog

Overview:
- Parametrised, runtime-programmable successor to the fixed N-bit prescaler.
- Divides clk_in by a loadable divisor D and produces two outputs:
  - a one-cycle tick strobe every D enabled cycles;
  - a 50%-duty clk_out of period 2*D.
- Sits between the board clock and slow consumers: automaton step timer, VGA pixel/line pacing, LED blinkers.
- Divisor changes are glitch-free via a shadow register.

Parameters:
- N, 22, counter and divisor width in bits.
- DIV_DEFAULT, 2**(N-1), divisor value loaded at reset; must fit in N bits.

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; 0 freezes the counter.
- div_in  input  N  new divisor value.
- div_load  input  1  one-cycle strobe; captures div_in into the shadow register.
- tick  output  1  one-cycle pulse on each terminal count.
- clk_out  output  1  divided clock; toggles on each tick.
- div_pend  output  1  high while a shadow value is waiting to be applied.
- count_out  output  N  current counter value.

Behaviour:
- Reset (async, rst=1) values:
  - count=0, tick=0, clk_out=0, div_pend=0;
  - active divisor div_q=DIV_DEFAULT;
  - shadow register shd=0.
- Wrap condition: en=1 && div_q!=0 && count==div_q-1.
- On a wrap edge:
  - count<=0, tick<=1, clk_out<=~clk_out;
  - if div_pend was set before the edge: div_q<=shd, div_pend<=0.
- On an enabled, non-wrap edge: count<=count+1, tick<=0.
- All outputs are registered. With en held high from reset, the first tick is high in the cycle after the D-th rising edge, then every D edges.
- en=0: count holds, tick<=0, clk_out holds.
- div_q==0: block halted. No ticks, count holds at 0, clk_out holds.
- div_q==1: tick is high every cycle; clk_out toggles every edge (clk_in/2).
- div_load=1 on an edge: shd<=div_in, div_pend<=1.
  - Immediate apply: if en=0 or div_q==0 at that edge, then div_q<=div_in, count<=0, div_pend<=0 in the same edge.
- div_load while div_pend=1: shd is overwritten; only the last value is applied.
- div_load on a wrap edge: the wrap applies the old shd (if it was pending); the new value becomes pending and is applied at the next wrap.
- Counter arithmetic is N-bit unsigned. count never exceeds div_q-1 because divisor changes occur only at count==0 boundaries.
- Reset mid-count: all state returns to reset values immediately, independent of clk_in.

Optional Feature:
- Macro: PRESCALER_ONESHOT_EN
- With the macro defined, two ports are added:
  - input oneshot (1 bit);
  - output done (1 bit, reset 0).
- When oneshot=1 and a wrap occurs:
  - tick fires once, done<=1;
  - count then freezes at 0; no further ticks or clk_out toggles while done=1.
- done clears, and counting re-arms, on the first edge with en=0.
- oneshot=0 gives free-running behaviour identical to the macro-absent build.
- Without the macro: ports absent; always free-running.

Test Plan:
- Reset, then en=1, div_q=4: tick high after edges 4, 8, 12 (period 4); clk_out period 8 with 50% duty; count_out cycles 0,1,2,3.
- div_q=5, count=2: load div_in=3 → div_pend=1; after wrap at edge +2, ticks every 3 edges; div_pend=0.
- en=0 with div_load div_in=7: div_q=7 immediately, count=0, div_pend stays 0; en=1 → first tick after 7 edges.
- Load div_in=0 then div_in=1 before the wrap: only 1 is applied; thereafter tick=1 every cycle. Then load 0 → halt at the next wrap; tick stays 0.
- Assert rst mid-count (count=3, clk_out=1): outputs go to 0 asynchronously; div_q=DIV_DEFAULT.
- PRESCALER_ONESHOT_EN build, oneshot=1, div_q=3: single tick at edge 3, done=1, no tick for 10 further edges; en=0 for one cycle → done=0; en=1 → next tick 3 edges later.
